// File: rtl/dac_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dac_tx
// Description : Sample-stream transmitter for a parallel 8-bit DAC. Signed
//               samples arrive over valid/ready, queue in a small FIFO and are
//               presented on the DAC bus at each dac_clk falling edge.
//               Optional macro DAC_TX_OFFSET_BINARY_EN selects offset-binary
//               output coding (sample ^ 8'h80, midscale 8'h80); otherwise the
//               bus carries the two's-complement sample (midscale 8'h00).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module dac_tx #(
   parameter int DIV_HALF   = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [7:0]                          s_data,
   input  logic                                s_valid,
   output logic                                s_ready,
   output logic [7:0]                          dac,
   output logic                                dac_clk,
   output logic                                underflow,
   output logic [$clog2(FIFO_DEPTH):0]         level
);

   localparam int CW = $clog2(DIV_HALF);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   localparam logic [CW-1:0] C_CNT_MAX = CW'(DIV_HALF - 1);
   localparam logic [LW-1:0] C_FULL    = LW'(FIFO_DEPTH);

`ifdef DAC_TX_OFFSET_BINARY_EN
   localparam logic [7:0] C_XOR_MASK = 8'h80;
   localparam logic [7:0] C_MIDSCALE = 8'h80;
`else
   localparam logic [7:0] C_XOR_MASK = 8'h00;
   localparam logic [7:0] C_MIDSCALE = 8'h00;
`endif

   logic [CW-1:0] cnt_q, cnt_d;
   logic          dac_clk_q, dac_clk_d;
   logic [7:0]    dac_q, dac_d;
   logic          underflow_q, underflow_d;
   logic          s_ready_q, s_ready_d;
   logic [LW-1:0] level_q, level_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];

   logic w_update;
   logic w_push;
   logic w_pop;

   // Divider, update-event detection, FIFO bookkeeping and output staging
   always_comb begin
      cnt_d       = cnt_q + 1'b1;
      dac_clk_d   = dac_clk_q;
      dac_d       = dac_q;
      underflow_d = 1'b0;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      level_d     = level_q;
      mem_d       = mem_q;

      if (cnt_q == C_CNT_MAX) begin
         cnt_d     = '0;
         dac_clk_d = ~dac_clk_q;
      end

      // The update event is the edge on which dac_clk falls
      w_update = (cnt_q == C_CNT_MAX) && dac_clk_q;
      w_pop    = w_update && (level_q != '0);
      w_push   = s_valid && s_ready_q;

      // A pushed sample is never bypassed to the bus: an event on an empty
      // FIFO underflows even if a push lands on the same edge
      if (w_update && (level_q == '0)) begin
         underflow_d = 1'b1;
      end

      if (w_pop) begin
         dac_d    = mem_q[rd_ptr_q] ^ C_XOR_MASK;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      if (w_push) begin
         mem_d[wr_ptr_q] = s_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end

      if (w_push && !w_pop) begin
         level_d = level_q + 1'b1;
      end else if (w_pop && !w_push) begin
         level_d = level_q - 1'b1;
      end

      // Ready reflects room after this edge's push/pop have settled
      s_ready_d = (level_d < C_FULL);
   end

   // State registers; asynchronous reset discards all queued samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         dac_clk_q   <= 1'b0;
         dac_q       <= C_MIDSCALE;
         underflow_q <= 1'b0;
         s_ready_q   <= 1'b0;
         level_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         dac_clk_q   <= dac_clk_d;
         dac_q       <= dac_d;
         underflow_q <= underflow_d;
         s_ready_q   <= s_ready_d;
         level_q     <= level_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         mem_q       <= mem_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign dac       = dac_q;
   assign dac_clk   = dac_clk_q;
   assign underflow = underflow_q;
   assign level     = level_q;

endmodule
`default_nettype wire

// File: doc/dac_tx.md
# dac_tx

Sample-stream transmitter that drives the parallel 8-bit DAC. It accepts signed filter output samples over a valid/ready handshake, buffers them in a small FIFO, and generates `dac_clk` from the 12 MHz system clock. The data bus updates on the `dac_clk` falling edge, so the converter latches a stable word on the rising edge. It is the output-side complement of the ADC capture path and replaces the direct filter-to-`dac` wire.

## Interface
- `DIV_HALF`, 12: `clk` cycles per `dac_clk` half-period. Must be ≥2. `dac_clk` period = 2·DIV_HALF cycles.
- `FIFO_DEPTH`, 4: sample buffer depth. Power of two, ≥2.
- `clk` in 1: system clock, 12 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `s_data` in 8: signed two's-complement sample.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: FIFO can accept a sample this cycle.
- `dac` out 8: DAC data bus.
- `dac_clk` out 1: DAC conversion clock.
- `underflow` out 1: one-cycle pulse when an update event finds the FIFO empty.
- `level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Divider**
  - Counter `cnt` runs 0..DIV_HALF-1.
  - When `cnt`==DIV_HALF-1: `cnt`←0 and `dac_clk` toggles. Otherwise `cnt`+1.
- **Update event**: the `clk` edge where `dac_clk` toggles 1→0.
  - FIFO non-empty: `dac`←converted head sample, head popped, `level`−1.
  - FIFO empty: `dac` holds its previous value; `underflow`=1 for that one cycle.
- **Push**
  - Occurs when `s_valid && s_ready`. Sample written at tail, `level`+1.
  - `s_ready` is a register, equal to (`level` < FIFO_DEPTH) computed from the post-update occupancy.
  - A push offered while full is not accepted. The source must hold `s_data`/`s_valid` until accepted.
- **Simultaneous push and pop**: both take effect and `level` is unchanged.
  - Full FIFO: `s_ready`=0 that cycle, so no push occurs.
  - Empty FIFO: no bypass. The pop reports `underflow`, the pushed sample stays queued for the next event, and `level` goes 0→1.
- **Pointers**: read/write pointers wrap modulo FIFO_DEPTH. `level` saturates at neither end because the handshake prevents overflow and the underflow rule prevents a pop on empty.
- **Arithmetic**: no scaling. Conversion is per the Configuration section only.

## Timing
- **Reset values**
  - `cnt`=0, `dac_clk`=0, `underflow`=0, `level`=0, FIFO empty.
  - `s_ready`=0; it becomes 1 at the first `clk` edge after release.
  - `dac`=midscale: 8'h80 with the macro, 8'h00 without.
- **`dac_clk` edges after reset release**
  - First rising edge at `clk` edge DIV_HALF.
  - First falling edge (first update event) at edge 2·DIV_HALF.
  - Subsequent update events every 2·DIV_HALF edges.
- **Latency and stability**
  - Accept-to-`dac` latency is variable: at most (level+1)·2·DIV_HALF cycles.
  - `dac` is stable for DIV_HALF `clk` cycles before each `dac_clk` rising edge and for DIV_HALF cycles after it.
- **Reset mid-operation**: asynchronous. All state returns to reset values immediately and FIFO contents are discarded. `dac_clk` may be truncated mid-period.
- `underflow` and `s_ready` are registered. `dac` and `dac_clk` are registered with no combinational path from inputs.

## Configuration
- Macro `DAC_TX_OFFSET_BINARY_EN`.
- **Defined**
  - `dac` = sample ^ 8'h80 (two's complement → offset binary for a unipolar DAC).
  - Reset/midscale value 8'h80. −128→8'h00, 0→8'h80, +127→8'hFF.
- **Undefined**
  - `dac` = sample unchanged (two's complement DAC).
  - Reset value 8'h00.

## Test plan
- **Reset and first edges**: hold `rst_n` low, then release. Expect `dac`=8'h80 (macro on), `dac_clk`=0, `s_ready`=0 then 1 one cycle later, first `dac_clk` rise at cycle 12, first fall at cycle 24.
- **Single sample**: push 8'sd100 at cycle 2. At the cycle-24 event expect `dac`=8'hE4 (macro on) or 8'h64 (off), `level` 1→0, no `underflow`.
- **Fill and backpressure**: push 5 samples back-to-back from reset release. Expect 4 accepted, `s_ready`=0 while `level`=4, 5th accepted the cycle after the first pop. Output order 1,2,3,4,5 on successive falling edges.
- **Underflow**: after the FIFO drains, the next update event gives `underflow`=1 for exactly one cycle with `dac` unchanged.
- **Push on empty at update event**: push lands on the same cycle as an update event with `level`=0. Expect `underflow`=1, `level`=1, sample appears at the next event 24 cycles later.
- **Mid-operation reset**: with `level`=3 and `dac_clk`=1, assert `rst_n`. Expect immediate `dac_clk`=0, `level`=0, `dac`=midscale. After release, no stale sample is ever output.
